// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Single-port load/store execution stage that sits directly after the memory
// issue queue. It takes one memory micro-op at a time and computes the
// effective address. It then runs a request/response handshake with data
// memory, aligns and extends the returned load data, and writes the result
// back on the common tag bus.
//
// The issued micro-op is presented as flat uop_in_* fields rather than a
// packed struct, so the block needs no shared package.
//
// Ports
//   clock                     sole clock, rising edge
//   reset                     asynchronous, active-low reset
//   uop_in_valid              issued op valid
//   uop_in_mem_type           MEM_LD (2'b01) / MEM_ST (2'b10); other codes ignored
//   uop_in_mem_size           0 = byte, 1 = half, 2 = word
//   uop_in_mem_signed         sign-extend load data
//   uop_in_imm                address offset, sign-extended to XLEN
//   uop_in_rd_prf_int_index   destination physical register tag
//   rs1_data / rs2_data       base operand / store data
//   ex_busy                   unit not idle; issue queue must not issue
//   dmem_req_*                memory request (word-aligned address, byte enables,
//                             lane-shifted store data), held until ready
//   dmem_resp_*               load response, full aligned word
//   ctb_*                     load writeback on the common tag bus
//   exc_valid / exc_addr      misaligned-access pulse and faulting address
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned XLEN               = 32,
    parameter int unsigned PRF_INT_INDEX_SIZE = 6,
    parameter int unsigned IMM_WIDTH          = 12
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic                          uop_in_valid,
    input  logic [1:0]                    uop_in_mem_type,
    input  logic [1:0]                    uop_in_mem_size,
    input  logic                          uop_in_mem_signed,
    input  logic [IMM_WIDTH-1:0]          uop_in_imm,
    input  logic [PRF_INT_INDEX_SIZE-1:0] uop_in_rd_prf_int_index,
    input  logic [XLEN-1:0]               rs1_data,
    input  logic [XLEN-1:0]               rs2_data,

    output logic                          ex_busy,

    output logic                          dmem_req_valid,
    input  logic                          dmem_req_ready,
    output logic [XLEN-1:0]               dmem_req_addr,
    output logic                          dmem_req_we,
    output logic [3:0]                    dmem_req_be,
    output logic [XLEN-1:0]               dmem_req_wdata,
    input  logic                          dmem_resp_valid,
    input  logic [XLEN-1:0]               dmem_resp_rdata,

    output logic                          ctb_valid,
    output logic [PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index,
    output logic [XLEN-1:0]               ctb_data,

    output logic                          exc_valid,
    output logic [XLEN-1:0]               exc_addr
);

    localparam logic [1:0] MEM_LD = 2'b01;
    localparam logic [1:0] MEM_ST = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_e;

    state_e state_q, state_d;

    // Transaction context latched at acceptance
    logic [XLEN-1:0]               ea_q, ea_d;
    logic [1:0]                    size_q, size_d;
    logic                          signed_q, signed_d;
    logic                          is_load_q, is_load_d;
    logic                          misal_q, misal_d;
    logic [PRF_INT_INDEX_SIZE-1:0] tag_q, tag_d;

    // Request fields are precomputed at acceptance and registered, so the
    // memory interface is driven straight from flops and stays stable while
    // the request is back-pressured.
    logic [XLEN-1:0]               req_addr_q, req_addr_d;
    logic [3:0]                    req_be_q, req_be_d;
    logic                          req_we_q, req_we_d;
    logic [XLEN-1:0]               req_wdata_q, req_wdata_d;

    // Writeback data (left at zero for a misaligned load)
    logic [XLEN-1:0]               data_q, data_d;

    // ---------------------------------------------------------------------
    // Acceptance-side decode
    // ---------------------------------------------------------------------
    logic            op_ld;
    logic            op_st;
    logic            accept;
    logic [XLEN-1:0] ea_calc;
    logic [1:0]      ea_off;
    logic            misal_calc;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;

    always_comb begin
        op_ld   = (uop_in_mem_type == MEM_LD);
        op_st   = (uop_in_mem_type == MEM_ST);
        accept  = (state_q == S_IDLE) && uop_in_valid && (op_ld || op_st);
        // Effective address wraps modulo 2^XLEN.
        ea_calc = rs1_data + {{(XLEN-IMM_WIDTH){uop_in_imm[IMM_WIDTH-1]}}, uop_in_imm};
        ea_off  = ea_calc[1:0];

        misal_calc = 1'b0;
        be_calc    = 4'b1111;
        case (uop_in_mem_size)
            2'd0: begin
                misal_calc = 1'b0;
                be_calc    = 4'b0001 << ea_off;
            end
            2'd1: begin
                misal_calc = ea_off[0];
                be_calc    = 4'b0011 << ea_off;
            end
            default: begin
                misal_calc = (ea_off != 2'b00);
                be_calc    = 4'b1111;
            end
        endcase

        wdata_calc = rs2_data << {ea_off, 3'b000};
    end

    // ---------------------------------------------------------------------
    // Load-data alignment and extension
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] resp_shifted;
    logic [XLEN-1:0] load_result;

    always_comb begin
        resp_shifted = dmem_resp_rdata >> {ea_q[1:0], 3'b000};
        case (size_q)
            2'd0:    load_result = {{(XLEN-8){signed_q & resp_shifted[7]}}, resp_shifted[7:0]};
            2'd1:    load_result = {{(XLEN-16){signed_q & resp_shifted[15]}}, resp_shifted[15:0]};
            default: load_result = resp_shifted;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = misal_calc ? S_WB : S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_req_ready) begin
                    state_d = req_we_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_resp_valid) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_comb begin
        ea_d        = ea_q;
        size_d      = size_q;
        signed_d    = signed_q;
        is_load_d   = is_load_q;
        misal_d     = misal_q;
        tag_d       = tag_q;
        req_addr_d  = req_addr_q;
        req_be_d    = req_be_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        data_d      = data_q;

        if (accept) begin
            ea_d        = ea_calc;
            size_d      = uop_in_mem_size;
            signed_d    = uop_in_mem_signed;
            is_load_d   = op_ld;
            misal_d     = misal_calc;
            tag_d       = uop_in_rd_prf_int_index;
            req_addr_d  = {ea_calc[XLEN-1:2], 2'b00};
            req_be_d    = be_calc;
            req_we_d    = op_st;
            req_wdata_d = wdata_calc;
            data_d      = '0;
        end else if ((state_q == S_WAIT) && dmem_resp_valid) begin
            data_d = load_result;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ea_q        <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            is_load_q   <= 1'b0;
            misal_q     <= 1'b0;
            tag_q       <= '0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            data_q      <= '0;
        end else begin
            ea_q        <= ea_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            is_load_q   <= is_load_d;
            misal_q     <= misal_d;
            tag_q       <= tag_d;
            req_addr_q  <= req_addr_d;
            req_be_q    <= req_be_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            data_q      <= data_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs, decoded from state and latched registers only
    // ---------------------------------------------------------------------
    always_comb begin
        ex_busy           = (state_q != S_IDLE);
        dmem_req_valid    = (state_q == S_REQ);
        dmem_req_addr     = req_addr_q;
        dmem_req_we       = req_we_q;
        dmem_req_be       = req_be_q;
        dmem_req_wdata    = req_wdata_q;
        // A misaligned load still pulses ctb (with zero data) so that
        // dependent ops are woken up.
        ctb_valid         = (state_q == S_WB) && is_load_q;
        ctb_prf_int_index = tag_q;
        ctb_data          = data_q;
        exc_valid         = (state_q == S_WB) && misal_q;
        exc_addr          = ea_q;
    end

endmodule
